// File: rtl/pac_pkg.sv
// Shared constants for the PAC pair scheduler: oscillator indices, pair table,
// class encodings, FSM states and the saturating product shift.
package pac_pkg;

  localparam int OSC_THETA      = 0;
  localparam int OSC_ALPHA      = 1;
  localparam int OSC_BETA_LOW   = 2;
  localparam int OSC_BETA_HIGH  = 3;
  localparam int OSC_GAMMA      = 4;
  localparam int OSC_GAMMA_FAST = 5;
  localparam int OSC_SR_F0      = 6;
  localparam int OSC_SR_F2      = 7;

  localparam int PAIR_CNT = 10;

  // Entry p holds pair p; listed from pair 9 down to pair 0.
  localparam logic [PAIR_CNT-1:0][2:0] PAIR_SLOW =
    {3'd0, 3'd6, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
  localparam logic [PAIR_CNT-1:0][2:0] PAIR_FAST =
    {3'd4, 3'd7, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd1};

  typedef enum logic [1:0] {
    ATTRACT  = 2'b00,
    TRANSIT  = 2'b01,
    BOUNDARY = 2'b10
  } pac_class_e;

  typedef enum logic [2:0] {
    IDLE, LATCH, DIV, REQ, WAIT, MUL_AMP, MUL_CHI, WRITE
  } pac_state_e;

  // Drop frac fractional bits, clamp to the largest w-bit value.
  function automatic logic [63:0] sat_shift(input logic [63:0] prod,
                                            input int frac, input int w);
    logic [63:0] s, lim;
    s   = prod >> frac;
    lim = (64'd1 << w) - 64'd1;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/pac_serial_div.sv
// Restoring divider: quotient = (dividend << FRAC) / divisor, one bit per cycle
// over WIDTH cycles; saturates to all ones on overflow or zero divisor.
module pac_serial_div #(
  parameter int WIDTH = 18,
  parameter int FRAC  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] dvd;
  logic [WIDTH-1:0]   rem, lo, dsr, q;
  logic [CW-1:0]      cnt;
  logic               run, sat;
  logic [WIDTH:0]     r2, diff;
  logic               ge;

  assign dvd = {{(WIDTH-FRAC){1'b0}}, dividend, {FRAC{1'b0}}};

  // Partial remainder stays below the divisor, so the borrow bit is the compare.
  assign r2   = {rem, lo[WIDTH-1]};
  assign diff = r2 - {1'b0, dsr};
  assign ge   = ~diff[WIDTH];

  assign done     = run && (cnt == CW'(WIDTH-1));
  assign quotient = sat ? '1 : q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      lo  <= '0;
      dsr <= '0;
      q   <= '0;
      cnt <= '0;
      run <= 1'b0;
      sat <= 1'b0;
    end else if (start) begin
      rem <= dvd[2*WIDTH-1:WIDTH];
      lo  <= dvd[WIDTH-1:0];
      dsr <= divisor;
      q   <= '0;
      cnt <= '0;
      run <= 1'b1;
      // Quotient fits WIDTH bits only if the high dividend half is below the divisor.
      sat <= (divisor == '0) || (dvd[2*WIDTH-1:WIDTH] >= divisor);
    end else if (run) begin
      rem <= ge ? diff[WIDTH-1:0] : r2[WIDTH-1:0];
      lo  <= lo << 1;
      q   <= {q[WIDTH-2:0], ge};
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/pac_pair_scheduler.sv
// Time-multiplexed PAC sequencer over the ten oscillator pairs.
// Optional macro PAC_CLASS_HYST_EN adds per-pair classification hysteresis.
module pac_pair_scheduler
  import pac_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int FRAC        = 14,
  parameter int NUM_OSC     = 8,
  parameter int NUM_PAIRS   = 10,
  parameter int LUT_ADDR_W  = 8,
  parameter int ATTRACT_TH  = 4096,
  parameter int BOUNDARY_TH = 12288,
  parameter int HYST        = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_OSC*WIDTH-1:0]  omega_flat,
  input  logic [NUM_OSC*WIDTH-1:0]  amp_flat,
  output logic                      lut_req,
  output logic [LUT_ADDR_W-1:0]     lut_addr,
  input  logic                      lut_gnt,
  input  logic                      lut_valid,
  input  logic [WIDTH-1:0]          lut_data,
  output logic [NUM_PAIRS*WIDTH-1:0] pac_flat,
  output logic [NUM_PAIRS*2-1:0]    class_flat,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int PW = $clog2(NUM_PAIRS);

`ifdef PAC_CLASS_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif
  // A zero margin makes the hysteresis rules collapse to plain thresholds.
  localparam int H = HYST_ON ? HYST : 0;
  localparam logic [WIDTH-1:0] UP_A = WIDTH'(ATTRACT_TH + H);
  localparam logic [WIDTH-1:0] DN_A = WIDTH'(ATTRACT_TH - H);
  localparam logic [WIDTH-1:0] UP_B = WIDTH'(BOUNDARY_TH + H);
  localparam logic [WIDTH-1:0] DN_B = WIDTH'(BOUNDARY_TH - H);

  pac_state_e state;
  logic [PW-1:0]                   pair;
  logic [WIDTH-1:0]                amp_s, amp_f, chi, amp_fac, pac_r;
  logic [NUM_PAIRS-1:0][WIDTH-1:0] pac_q;
  logic [NUM_PAIRS-1:0][1:0]       cls_q;

  logic [2:0]         slow_idx, fast_idx;
  logic [WIDTH-1:0]   ratio;
  logic               div_done;
  logic [WIDTH-1:0]   mul_a, mul_b, mul_sat;
  logic [2*WIDTH-1:0] prod;
  pac_class_e         prev_cls, cls_new;
  logic               unused_ratio_bits;

  assign slow_idx = PAIR_SLOW[pair];
  assign fast_idx = PAIR_FAST[pair];

  // Divider loads the live omegas on the same edge that snapshots the amplitudes.
  pac_serial_div #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == LATCH),
    .dividend (omega_flat[fast_idx*WIDTH +: WIDTH]),
    .divisor  (omega_flat[slow_idx*WIDTH +: WIDTH]),
    .done     (div_done),
    .quotient (ratio)
  );

  // The divider holds its result until the next LATCH, so the address is stable in REQ.
  assign lut_addr = ratio[FRAC+2 -: LUT_ADDR_W];
  assign unused_ratio_bits = ^{ratio[WIDTH-1:FRAC+3], ratio[FRAC+2-LUT_ADDR_W:0]};

  always_comb begin
    mul_a = chi;
    mul_b = amp_fac;
    if (state == MUL_AMP) begin
      mul_a = amp_s;
      mul_b = amp_f;
    end
  end

  assign prod    = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
  assign mul_sat = WIDTH'(sat_shift(64'(prod), FRAC, WIDTH));

  always_comb begin
    prev_cls = pac_class_e'(cls_q[pair]);
    cls_new  = prev_cls;
    case (prev_cls)
      ATTRACT: begin
        if (chi >= UP_B)      cls_new = BOUNDARY;
        else if (chi >= UP_A) cls_new = TRANSIT;
      end
      BOUNDARY: begin
        if (chi < DN_A)       cls_new = ATTRACT;
        else if (chi < DN_B)  cls_new = TRANSIT;
      end
      default: begin
        if (chi < DN_A)       cls_new = ATTRACT;
        else if (chi >= UP_B) cls_new = BOUNDARY;
        else                  cls_new = TRANSIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pair       <= '0;
      amp_s      <= '0;
      amp_f      <= '0;
      chi        <= '0;
      amp_fac    <= '0;
      pac_r      <= '0;
      pac_q      <= '0;
      cls_q      <= '0;
      lut_req    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= start && (state != IDLE);
      case (state)
        IDLE: if (start) begin
          state <= LATCH;
          pair  <= '0;
          busy  <= 1'b1;
        end
        LATCH: begin
          amp_s <= amp_flat[slow_idx*WIDTH +: WIDTH];
          amp_f <= amp_flat[fast_idx*WIDTH +: WIDTH];
          state <= DIV;
        end
        DIV: if (div_done) begin
          lut_req <= 1'b1;
          state   <= REQ;
        end
        REQ: if (lut_gnt) begin
          lut_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (lut_valid) begin
          chi   <= lut_data;
          state <= MUL_AMP;
        end
        MUL_AMP: begin
          amp_fac <= mul_sat;
          state   <= MUL_CHI;
        end
        MUL_CHI: begin
          pac_r <= mul_sat;
          state <= WRITE;
        end
        WRITE: begin
          pac_q[pair] <= pac_r;
          cls_q[pair] <= cls_new;
          if (pair == PW'(NUM_PAIRS-1)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            pair  <= pair + 1'b1;
            state <= LATCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pac_flat   = pac_q;
  assign class_flat = cls_q;

endmodule
